// File: rtl/serdesphy_cdr_vco_ctrl.sv
// CDR VCO sequencer: enable, wait ready, 8-step binary-search calibration, then PD-driven tracking with lock detect.
// Latency: all outputs registered; calibration takes 8*(SETTLE_CYCLES+WIN_CYCLES+1) cycles after vco_ready_i is seen.
// Backpressure: none; start_i is a level, and dropping it returns to IDLE on the next cycle from any state.
//
// Ports:
//   clk_i, rst_i       controller clock, synchronous active-high reset
//   start_i            level: high runs the sequence, low aborts to IDLE
//   vco_ready_i        VCO stable flag (already synchronised)
//   vco_edge_i         one-cycle pulse per VCO rising edge (already synchronised)
//   pd_up_i, pd_dn_i   phase detector: VCO too slow / too fast
//   vco_enable_o       VCO enable
//   cdr_control_o      8-bit VCO control code
//   cal_done_o         calibration finished, tracking active
//   locked_o           tracking loop locked
//   fault_o            ready timeout or ready lost
//   busy_o             sequencer not in IDLE
module serdesphy_cdr_vco_ctrl #(
  parameter int unsigned WIN_CYCLES    = 256,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TARGET_COUNT  = 100,
  parameter int unsigned READY_TIMEOUT = 1024,
  parameter int unsigned LOCK_TOL      = 2,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter logic [7:0]  CODE_MIN      = 8'h20,
  parameter logic [7:0]  CODE_MAX      = 8'hE0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       vco_ready_i,
  input  logic       vco_edge_i,
  input  logic       pd_up_i,
  input  logic       pd_dn_i,
  output logic       vco_enable_o,
  output logic [7:0] cdr_control_o,
  output logic       cal_done_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    EN_WAIT,
    CAL_SETTLE,
    CAL_MEAS,
    CAL_UPD,
    TRACK,
    FAULT
  } state_e;

  localparam logic [7:0] CODE_RST = 8'h80;

  // One shared cycle counter serves the ready timeout, settle, measurement
  // and lock windows, so it is sized for the longest of them.
  localparam int unsigned CNT_MAX_A = (READY_TIMEOUT > WIN_CYCLES) ? READY_TIMEOUT : WIN_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int          CNT_W     = $clog2(CNT_MAX);
  localparam int          QW        = $clog2(LOCK_WINDOWS + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        edge_cnt_q, edge_cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         code_q, code_d;
  logic signed [15:0] net_q, net_d;
  logic signed [15:0] net_fin;
  logic [15:0]        net_abs;
  logic [QW-1:0]      quiet_q, quiet_d;
  logic               en_q, en_d;
  logic               cal_done_q, cal_done_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;
  logic               ready_lost;

  // Net phase-detector balance including this cycle's pulse, so the
  // window-end decision sees every pulse of the window.
  always_comb begin
    net_fin = net_q;
    if (pd_up_i && !pd_dn_i) begin
      net_fin = net_q + 16'sd1;
    end else if (pd_dn_i && !pd_up_i) begin
      net_fin = net_q - 16'sd1;
    end
  end

  assign net_abs = net_fin[15] ? $unsigned(-net_fin) : $unsigned(net_fin);

  assign ready_lost = !vco_ready_i &&
                      (state_q == CAL_SETTLE || state_q == CAL_MEAS ||
                       state_q == CAL_UPD    || state_q == TRACK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    bit_d      = bit_q;
    code_d     = code_q;
    net_d      = net_q;
    quiet_d    = quiet_q;
    en_d       = en_q;
    cal_done_d = cal_done_q;
    locked_d   = locked_q;
    fault_d    = fault_q;

    // Abort wins over every other transition, including a fault in the same cycle.
    if (state_q != IDLE && !start_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      en_d       = 1'b0;
      code_d     = CODE_RST;
      cal_done_d = 1'b0;
      locked_d   = 1'b0;
      fault_d    = 1'b0;
    end else if (ready_lost) begin
      state_d    = FAULT;
      cnt_d      = '0;
      en_d       = 1'b0;
      code_d     = CODE_RST;
      cal_done_d = 1'b0;
      locked_d   = 1'b0;
      fault_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          en_d   = 1'b0;
          code_d = CODE_RST;
          if (start_i) begin
            state_d = EN_WAIT;
            en_d    = 1'b1;
            cnt_d   = '0;
          end
        end

        EN_WAIT: begin
          if (vco_ready_i) begin
            state_d = CAL_SETTLE;
            cnt_d   = '0;
            bit_d   = 3'd7;
            code_d  = CODE_RST;
          end else if (cnt_q == CNT_W'(READY_TIMEOUT - 1)) begin
            state_d = FAULT;
            cnt_d   = '0;
            en_d    = 1'b0;
            code_d  = CODE_RST;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        CAL_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d    = CAL_MEAS;
            cnt_d      = '0;
            edge_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        CAL_MEAS: begin
          if (vco_edge_i && edge_cnt_q != 16'hFFFF) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
          end
          if (cnt_q == CNT_W'(WIN_CYCLES - 1)) begin
            state_d = CAL_UPD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        CAL_UPD: begin
          // Too many edges means the trial code is too high: drop the bit.
          if (edge_cnt_q > 16'(TARGET_COUNT)) begin
            code_d[bit_q] = 1'b0;
          end
          if (bit_q != 3'd0) begin
            code_d[bit_q - 3'd1] = 1'b1;
            bit_d                = bit_q - 3'd1;
            state_d              = CAL_SETTLE;
          end else begin
            // Only the final search result is clamped; trials run unclamped.
            if (code_d < CODE_MIN) begin
              code_d = CODE_MIN;
            end else if (code_d > CODE_MAX) begin
              code_d = CODE_MAX;
            end
            state_d    = TRACK;
            cal_done_d = 1'b1;
            locked_d   = 1'b0;
            net_d      = '0;
            quiet_d    = '0;
          end
          cnt_d = '0;
        end

        TRACK: begin
          if (pd_up_i && !pd_dn_i) begin
            code_d = (code_q >= CODE_MAX) ? CODE_MAX : code_q + 8'd1;
          end else if (pd_dn_i && !pd_up_i) begin
            code_d = (code_q <= CODE_MIN) ? CODE_MIN : code_q - 8'd1;
          end
          if (cnt_q == CNT_W'(WIN_CYCLES - 1)) begin
            cnt_d = '0;
            net_d = '0;
            if (net_abs <= 16'(LOCK_TOL)) begin
              if (quiet_q != QW'(LOCK_WINDOWS)) begin
                quiet_d = quiet_q + 1'b1;
              end
              locked_d = (quiet_d == QW'(LOCK_WINDOWS));
            end else begin
              quiet_d  = '0;
              locked_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            net_d = net_fin;
          end
        end

        FAULT: begin
          // Held until start_i drops; outputs were set on entry.
          en_d   = 1'b0;
          code_d = CODE_RST;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      bit_q      <= '0;
      code_q     <= CODE_RST;
      net_q      <= '0;
      quiet_q    <= '0;
      en_q       <= 1'b0;
      cal_done_q <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      net_q      <= net_d;
      quiet_q    <= quiet_d;
      en_q       <= en_d;
      cal_done_q <= cal_done_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign vco_enable_o  = en_q;
  assign cdr_control_o = code_q;
  assign cal_done_o    = cal_done_q;
  assign locked_o      = locked_q;
  assign fault_o       = fault_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_serdesphy_cdr_vco_ctrl.sv
// Bench for serdesphy_cdr_vco_ctrl: three instances differing only in TARGET_COUNT share stimulus.
// Each instance sees a VCO model producing exactly cdr_control edges in any 256-cycle span.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_serdesphy_cdr_vco_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       vco_ready;
  logic       pd_up;
  logic       pd_dn;
  logic       edge0, edge1, edge2;
  logic       en0, en1, en2;
  logic [7:0] ctl0, ctl1, ctl2;
  logic       cd0, cd1, cd2;
  logic       lk0, lk1, lk2;
  logic       ft0, ft1, ft2;
  logic       bz0, bz1, bz2;

  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] phase  = 8'd0;
  logic [7:0] sb_q[$];
  logic [7:0] mcode;

  typedef struct {
    logic       up;
    logic       dn;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    phase <= phase + 8'd1;
  end

  // Over any 256 consecutive cycles phase takes every value once, so the
  // number of edges equals the control code.
  assign edge0 = en0 && (phase < ctl0);
  assign edge1 = en1 && (phase < ctl1);
  assign edge2 = en2 && (phase < ctl2);

  serdesphy_cdr_vco_ctrl #(.TARGET_COUNT(100)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vco_ready_i(vco_ready),
    .vco_edge_i(edge0), .pd_up_i(pd_up), .pd_dn_i(pd_dn),
    .vco_enable_o(en0), .cdr_control_o(ctl0), .cal_done_o(cd0),
    .locked_o(lk0), .fault_o(ft0), .busy_o(bz0)
  );

  serdesphy_cdr_vco_ctrl #(.TARGET_COUNT(20)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vco_ready_i(vco_ready),
    .vco_edge_i(edge1), .pd_up_i(pd_up), .pd_dn_i(pd_dn),
    .vco_enable_o(en1), .cdr_control_o(ctl1), .cal_done_o(cd1),
    .locked_o(lk1), .fault_o(ft1), .busy_o(bz1)
  );

  serdesphy_cdr_vco_ctrl #(.TARGET_COUNT(250)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vco_ready_i(vco_ready),
    .vco_edge_i(edge2), .pd_up_i(pd_up), .pd_dn_i(pd_dn),
    .vco_enable_o(en2), .cdr_control_o(ctl2), .cal_done_o(cd2),
    .locked_o(lk2), .fault_o(ft2), .busy_o(bz2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Largest code whose edge count does not exceed the target, then clamped.
  function automatic logic [7:0] cal_model(input int target);
    int code = 0;
    for (int b = 7; b >= 0; b--) begin
      if ((code | (1 << b)) <= target) code = code | (1 << b);
    end
    if (code < 'h20) code = 'h20;
    if (code > 'hE0) code = 'hE0;
    return 8'(code);
  endfunction

  task automatic step_pd(input logic up, input logic dn);
    pd_up = up;
    pd_dn = dn;
    if (up && !dn)      mcode = (mcode >= 8'hE0) ? 8'hE0 : mcode + 8'd1;
    else if (dn && !up) mcode = (mcode <= 8'h20) ? 8'h20 : mcode - 8'd1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_ready;
    int t_track;
    int t_en;
    int n;
    logic [7:0] e;

    vecs[0] = '{1'b1, 1'b0, 8'hE0};
    vecs[1] = '{1'b1, 1'b0, 8'hE0};
    vecs[2] = '{1'b1, 1'b0, 8'hE0};
    vecs[3] = '{1'b1, 1'b1, 8'hE0};
    vecs[4] = '{1'b0, 1'b0, 8'hE0};
    vecs[5] = '{1'b0, 1'b1, 8'hDF};
    vecs[6] = '{1'b1, 1'b1, 8'hDF};
    vecs[7] = '{1'b0, 1'b1, 8'hDE};
    vecs[8] = '{1'b1, 1'b0, 8'hDF};
    vecs[9] = '{1'b0, 1'b0, 8'hDF};

    rst = 1'b1; start = 1'b0; vco_ready = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
    mcode = 8'h80;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_enable", en0, 0);
    chk("rst_control", ctl0, 8'h80);
    chk("rst_cal_done", cd0, 0);
    chk("rst_locked", lk0, 0);
    chk("rst_fault", ft0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_others", {en1, cd1, lk1, ft1, bz1, en2, cd2, lk2, ft2, bz2}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold_busy", bz0, 0);

    // Calibration with ready 10 cycles after enable
    start = 1'b1;
    @(negedge clk);
    chk("start_enable", en0, 1);
    chk("start_busy", bz0, 1);
    chk("en_wait_control", ctl0, 8'h80);
    repeat (9) @(negedge clk);
    vco_ready = 1'b1;
    t_ready = cyc + 1;
    sb_q.push_back(cal_model(100));
    sb_q.push_back(cal_model(20));
    sb_q.push_back(cal_model(250));
    n = 0;
    while (!cd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cal_done_seen", cd0, 1);
    chk("cal_latency", cyc - t_ready, 8 * 273);
    e = sb_q.pop_front(); chk("cal_code_t100", ctl0, e);
    e = sb_q.pop_front(); chk("cal_code_t20", ctl1, e);
    e = sb_q.pop_front(); chk("cal_code_t250", ctl2, e);
    chk("cal_done_others", {cd1, cd2}, 2'b11);
    chk("cal_not_locked", lk0, 0);

    // Lock detection: alternating up/dn keeps each window balanced
    t_track = cyc;
    mcode = cal_model(100);
    for (int i = 0; i < 1023; i++) begin
      if (i % 2 == 0) step_pd(1'b1, 1'b0);
      else            step_pd(1'b0, 1'b1);
    end
    chk("lock_before_4th", lk0, 0);
    step_pd(1'b0, 1'b1);
    chk("lock_window_pos", cyc - t_track, 1024);
    chk("lock_at_4th", lk0, 1);
    for (int i = 0; i < 255; i++) begin
      if (i < 10) step_pd(1'b1, 1'b0);
      else        step_pd(1'b0, 1'b0);
    end
    chk("lock_held_in_window", lk0, 1);
    step_pd(1'b0, 1'b0);
    chk("unlock_at_window_end", lk0, 0);

    // Tracking code updates and clamps
    chk("track_follow", ctl0, mcode);
    n = 0;
    while (mcode != 8'hDF && n < 300) begin
      step_pd(1'b1, 1'b0);
      n++;
    end
    chk("track_reach_df", ctl0, 8'hDF);
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(vecs[i].exp);
      step_pd(vecs[i].up, vecs[i].dn);
      e = sb_q.pop_front();
      chk($sformatf("trk_vec%0d", i), ctl0, e);
    end
    n = 0;
    while (mcode != 8'h20 && n < 300) begin
      step_pd(1'b0, 1'b1);
      n++;
    end
    repeat (3) step_pd(1'b0, 1'b1);
    chk("track_floor", ctl0, 8'h20);
    step_pd(1'b0, 1'b0);

    // Abort mid-TRACK
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", bz0, 0);
    chk("abort_cal_done", cd0, 0);
    chk("abort_control", ctl0, 8'h80);
    chk("abort_enable", en0, 0);

    // Ready loss mid-measurement
    start = 1'b1;
    @(negedge clk);
    chk("restart_enable", en0, 1);
    repeat (60) @(negedge clk);
    chk("meas_no_fault", ft0, 0);
    vco_ready = 1'b0;
    @(negedge clk);
    chk("ready_loss_fault", ft0, 1);
    chk("ready_loss_enable", en0, 0);
    chk("ready_loss_control", ctl0, 8'h80);
    chk("ready_loss_busy", bz0, 1);
    start = 1'b0;
    @(negedge clk);
    chk("fault_exit_fault", ft0, 0);
    chk("fault_exit_busy", bz0, 0);

    // Abort and ready loss together: abort wins
    vco_ready = 1'b1;
    start = 1'b1;
    repeat (5) @(negedge clk);
    vco_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("prio_fault", ft0, 0);
    chk("prio_busy", bz0, 0);

    // Ready timeout
    start = 1'b1;
    @(negedge clk);
    chk("to_enable", en0, 1);
    t_en = cyc;
    n = 0;
    while (!ft0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("to_fault", ft0, 1);
    chk("to_latency", cyc - t_en, 1024);
    chk("to_enable_off", en0, 0);
    chk("to_control", ctl0, 8'h80);
    start = 1'b0;
    @(negedge clk);
    chk("to_exit_fault", ft0, 0);
    chk("to_exit_busy", bz0, 0);

    // Reset mid-calibration
    vco_ready = 1'b1;
    start = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_enable", en0, 0);
    chk("midrst_busy", bz0, 0);
    chk("midrst_control", ctl0, 8'h80);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
